// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding, load-use and memory-wait hazard control.
// Forward selects are computed from IF/ID and registered into ID/EX.
module hazard_forward_unit #(
  parameter int REGW = 5,
  parameter int CNTW = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic [REGW-1:0] ifid_rs,
  input  logic [REGW-1:0] ifid_rt,
  input  logic            ifid_use_rs,
  input  logic            ifid_use_rt,
  input  logic [REGW-1:0] idex_rd,
  input  logic            idex_regwrite,
  input  logic [1:0]      idex_wsel,
  input  logic [REGW-1:0] exmem_rd,
  input  logic            exmem_regwrite,
  input  logic            exmem_memop,
  input  logic            flush_req,
  output logic [2:0]      forwarda,
  output logic [2:0]      forwardb,
  output logic            pc_en,
  output logic            idex_en,
  output logic            idex_bubble,
  output logic            dwait,
  output logic [CNTW-1:0] stall_count
);

  localparam logic [2:0] FW_RF   = 3'b000;
  localparam logic [2:0] FW_ALU  = 3'b001;
  localparam logic [2:0] FW_WB   = 3'b010;
  localparam logic [2:0] FW_LUI  = 3'b011;
  localparam logic [2:0] FW_PASS = 3'b111;

  localparam logic [1:0] WS_ALU  = 2'd0;
  localparam logic [1:0] WS_LUI  = 2'd1;
  localparam logic [1:0] WS_PASS = 2'd2;
  localparam logic [1:0] WS_LOAD = 2'd3;

  typedef enum logic {RUN, DWAIT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      fwda_q, fwda_d;
  logic [2:0]      fwdb_q, fwdb_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic       mem_wait;
  logic       load_use;
  logic [2:0] code_a;
  logic [2:0] code_b;

  // Most recent writer (ID/EX) wins over EX/MEM.
  function automatic logic [2:0] fwd_code(
    input logic [REGW-1:0] r,
    input logic            u,
    input logic [REGW-1:0] ex_rd,
    input logic            ex_we,
    input logic [1:0]      ex_ws,
    input logic [REGW-1:0] mem_rd,
    input logic            mem_we
  );
    logic [2:0] c;
    c = FW_RF;
    if (!u || r == '0) begin
      c = FW_RF;
    end else if (ex_we && ex_rd == r) begin
      case (ex_ws)
        WS_ALU:  c = FW_ALU;
        WS_LUI:  c = FW_LUI;
        WS_PASS: c = FW_PASS;
        default: c = FW_RF;
      endcase
    end else if (mem_we && mem_rd == r) begin
      c = FW_WB;
    end
    return c;
  endfunction

  always_comb begin
    mem_wait = exmem_memop & ~dhit;
    load_use = idex_regwrite & (idex_wsel == WS_LOAD)
             & (idex_rd != '0)
             & ((ifid_use_rs & (ifid_rs == idex_rd))
              | (ifid_use_rt & (ifid_rt == idex_rd)));
    code_a = fwd_code(ifid_rs, ifid_use_rs, idex_rd,
                      idex_regwrite, idex_wsel,
                      exmem_rd, exmem_regwrite);
    code_b = fwd_code(ifid_rt, ifid_use_rt, idex_rd,
                      idex_regwrite, idex_wsel,
                      exmem_rd, exmem_regwrite);
  end

  always_comb begin
    state_d     = state_q;
    fwda_d      = fwda_q;
    fwdb_d      = fwdb_q;
    pc_en       = 1'b1;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;

    if (mem_wait) begin
      state_d = DWAIT;
    end else if (state_q == DWAIT && !dhit) begin
      state_d = DWAIT;
    end else begin
      state_d = RUN;
    end

    if (!nRST) begin
      pc_en   = 1'b0;
      idex_en = 1'b0;
    end else if (mem_wait) begin
      pc_en   = 1'b0;
      idex_en = 1'b0;
    end else if (!ihit) begin
      pc_en       = 1'b0;
      idex_bubble = 1'b1;
      fwda_d      = FW_RF;
      fwdb_d      = FW_RF;
    end else if (flush_req) begin
      idex_bubble = 1'b1;
      fwda_d      = FW_RF;
      fwdb_d      = FW_RF;
    end else if (load_use) begin
      pc_en       = 1'b0;
      idex_bubble = 1'b1;
      fwda_d      = FW_RF;
      fwdb_d      = FW_RF;
    end else begin
      fwda_d = code_a;
      fwdb_d = code_b;
    end

    cnt_d = cnt_q;
    if (!pc_en && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= RUN;
      fwda_q  <= FW_RF;
      fwdb_q  <= FW_RF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fwda_q  <= fwda_d;
      fwdb_q  <= fwdb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign forwarda    = fwda_q;
  assign forwardb    = fwdb_q;
  assign dwait       = (state_q == DWAIT);
  assign stall_count = cnt_q;

endmodule
